// File: rtl/filter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_sched_pkg
// Brief    : Shared types and default widths for the filter round-robin scheduler.
// Revision : 1.0
// ============================================================================
package filter_sched_pkg;

    localparam int C_N_REQ  = 4;
    localparam int C_DW     = 16;
    localparam int C_ID_W   = 2;
    localparam int C_TO_CYC = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        COOL     = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/filter_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_rr_sched_if
// Brief    : Requester, filter and result signals of the round-robin scheduler.
// Revision : 1.0
// ============================================================================
interface filter_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic                flt_rdy;
    logic [DW-1:0]       flt_din;
    logic                flt_ack;
    logic [DW-1:0]       flt_dout;
    logic                res_valid;
    logic [DW-1:0]       res_data;
    logic [ID_W-1:0]     res_id;
    logic                busy;
    logic                to_err;

    // Scheduler side
    modport slave (
        input  req, req_data, flt_ack, flt_dout,
        output gnt, flt_rdy, flt_din, res_valid, res_data, res_id, busy, to_err
    );

    // Environment side (requesters, filter, downstream consumer)
    modport master (
        output req, req_data, flt_ack, flt_dout,
        input  gnt, flt_rdy, flt_din, res_valid, res_data, res_id, busy, to_err
    );
endinterface
`default_nettype wire

// File: rtl/filter_rr_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic [ID_W-1:0]  ptr_i,
    output logic      [ID_W-1:0]  winner_o,
    output logic                  any_o
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down so the closest request to ptr wins;
    // the ID_W-bit add wraps modulo N_REQ because N_REQ is a power of two.
    always_comb begin
        winner_o = '0;
        w_idx    = '0;
        any_o    = |req_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = ptr_i + ID_W'(i);
            if (req_i[w_idx]) begin
                winner_o = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : filter_rr_sched
// Brief    : Round-robin scheduler sharing one filter datapath among N_REQ
//            requesters. Optional Ack timeout: FLT_SCHED_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module filter_rr_sched
    import filter_sched_pkg::*;
#(
    parameter int N_REQ  = C_N_REQ,
    parameter int DW     = C_DW,
    parameter int ID_W   = C_ID_W,
    parameter int TO_CYC = C_TO_CYC
) (
    input  wire logic         clk,
    input  wire logic         reset,
    filter_rr_sched_if.slave  bus
);

    if (((1 << ID_W) != N_REQ) || (N_REQ < 2) || (N_REQ > 8) || (TO_CYC < 1)) begin : g_param_check
        $error("filter_rr_sched: inconsistent N_REQ/ID_W/TO_CYC");
    end

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic            rdy_q, rdy_d;
    logic [DW-1:0]   din_q, din_d;
    logic            rv_q, rv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic            to_err_q, to_err_d;

    logic [ID_W-1:0] w_winner;
    logic            w_any;

`ifdef FLT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TO_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rdy_q    <= 1'b0;
            din_q    <= '0;
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            to_err_q <= 1'b0;
`ifdef FLT_SCHED_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rdy_q    <= rdy_d;
            din_q    <= din_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            to_err_q <= to_err_d;
`ifdef FLT_SCHED_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Pulses (gnt, flt_rdy, res_valid, to_err) default low; data words hold.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rdy_d    = 1'b0;
        din_d    = din_q;
        rv_d     = 1'b0;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        to_err_d = 1'b0;
`ifdef FLT_SCHED_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    gnt_d[w_winner] = 1'b1;
                    din_d           = bus.req_data[w_winner*DW +: DW];
                    rdy_d           = 1'b1;
                    rid_d           = w_winner;
                    ptr_d           = w_winner + 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
`ifdef FLT_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_ACK: begin
                if (bus.flt_ack) begin
                    rdata_d = bus.flt_dout;
                    rv_d    = 1'b1;
                    state_d = COOL;
                end
`ifdef FLT_SCHED_TIMEOUT_EN
                else if (cnt_q == C_CNT_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = COOL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            COOL: begin
                // Gives the filter a cycle to return from Ready before a new Rdy.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.gnt       = gnt_q;
        bus.flt_rdy   = rdy_q;
        bus.flt_din   = din_q;
        bus.res_valid = rv_q;
        bus.res_data  = rdata_q;
        bus.res_id    = rid_q;
        bus.busy      = (state_q != IDLE);
        bus.to_err    = to_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_rr_sched
// Brief    : Self-checking bench for filter_rr_sched with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_filter_rr_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int NC = 2048;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic stuck = 1'b0;
    logic spur  = 1'b0;
    logic f_ack = 1'b0;
    logic [DW-1:0] f_dout = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    filter_rr_sched_if #(.N_REQ(N), .DW(DW), .ID_W(IW)) bus ();

    filter_rr_sched #(
        .N_REQ  (N),
        .DW     (DW),
        .ID_W   (IW),
        .TO_CYC (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] filt(input logic [DW-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'h0F0F;
    endfunction

    // Stand-in filter: acks one cycle after Rdy unless stuck; spur injects stray Acks.
    always @(posedge clk) begin
        f_ack <= bus.flt_rdy && !stuck;
        if (bus.flt_rdy) f_dout <= filt(bus.flt_din);
    end
    assign bus.flt_ack  = f_ack | spur;
    assign bus.flt_dout = f_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Expected per-cycle outputs, filled in by whole transactions at decision time.
    logic [N-1:0]  e_gnt [NC];
    bit            e_rdy [NC];
    bit            e_busy[NC];
    bit            e_rv  [NC];
    bit            e_to  [NC];
    logic [DW-1:0] e_rd  [NC];
    int            m_ptr  = 0;
    int            m_free = 0;
    logic [DW-1:0] m_din   = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [IW-1:0] m_rid   = '0;

    always @(posedge clk) begin
        int w;
        int last;
        cyc++;
        if (reset) begin
            for (int c = cyc; c < NC; c++) begin
                e_gnt[c] = '0; e_rdy[c] = 0; e_busy[c] = 0;
                e_rv[c]  = 0;  e_to[c]  = 0; e_rd[c]   = '0;
            end
            m_ptr = 0; m_free = cyc + 1;
            m_din = '0; m_rid = '0; m_rdata = '0;
        end else if (cyc >= m_free && bus.req != '0 && cyc + 20 < NC) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            e_gnt[cyc]    = '0;
            e_gnt[cyc][w] = 1'b1;
            e_rdy[cyc]    = 1;
            m_din = bus.req_data[w*DW +: DW];
            m_rid = IW'(w);
            m_ptr = (w + 1) % N;
            if (!stuck) begin
                last = cyc + 2;
                e_rv[cyc + 2] = 1;
                e_rd[cyc + 2] = filt(m_din);
                m_free = cyc + 4;
            end else begin
`ifdef FLT_SCHED_TIMEOUT_EN
                last = cyc + 16;
                e_to[cyc + 16] = 1;
                m_free = cyc + 18;
`else
                last = NC - 1;
                m_free = NC;
`endif
            end
            for (int c = cyc; c <= last && c < NC; c++) e_busy[c] = 1;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            if (e_rv[cyc]) m_rdata = e_rd[cyc];
            chk("gnt",       32'(bus.gnt),       32'(e_gnt[cyc]));
            chk("flt_rdy",   32'(bus.flt_rdy),   32'(e_rdy[cyc]));
            chk("flt_din",   32'(bus.flt_din),   32'(m_din));
            chk("res_valid", 32'(bus.res_valid), 32'(e_rv[cyc]));
            chk("res_data",  32'(bus.res_data),  32'(m_rdata));
            chk("res_id",    32'(bus.res_id),    32'(m_rid));
            chk("busy",      32'(bus.busy),      32'(e_busy[cyc]));
            chk("to_err",    32'(bus.to_err),    32'(e_to[cyc]));
        end
    end

    task automatic wait_gnt(output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                for (int k = 0; k < N; k++) if (bus.gnt[k]) idx = k;
                at = cyc;
                break;
            end
        end
        if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: no grant within 40 cycles (got none, required one)");
        end
    endtask

    initial begin
        int idx, at, at_prev, seen;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        at_prev = 0;
        bus.req      = '0;
        bus.req_data = {16'hD4D4, 16'hC3C3, 16'h1234, 16'hA1A1};
        repeat (3) @(negedge clk);
        chk("lit_rst_gnt",  32'(bus.gnt), 0);
        chk("lit_rst_busy", 32'(bus.busy), 0);
        chk("lit_rst_din",  32'(bus.flt_din), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single request from requester 1
        bus.req = 4'b0010;
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_single_id",  idx, 1);
        chk("lit_single_rdy", 32'(bus.flt_rdy), 1);
        chk("lit_single_din", 32'(bus.flt_din), 32'h1234);
        @(negedge clk);
        chk("lit_single_gnt_off", 32'(bus.gnt), 0);
        chk("lit_single_rdy_off", 32'(bus.flt_rdy), 0);
        @(negedge clk);
        chk("lit_single_rv",    32'(bus.res_valid), 1);
        chk("lit_single_resid", 32'(bus.res_id), 1);
        chk("lit_single_rdata", 32'(bus.res_data), 32'h3B1D);
        repeat (2) @(negedge clk);

        // Stray Ack while idle
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("lit_spur_rv",   32'(bus.res_valid), 0);
        chk("lit_spur_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);

        // All four continuously requesting from reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.req = '1;
        for (int t = 0; t < 5; t++) begin
            wait_gnt(idx, at);
            if (t == 4) bus.req = '0;
            chk($sformatf("lit_rr_order%0d", t), idx, order[t]);
            if (t > 0) chk("lit_rr_spacing", at - at_prev, 4);
            at_prev = at;
            repeat (2) @(negedge clk);
            chk("lit_rr_rv",    32'(bus.res_valid), 1);
            chk("lit_rr_resid", 32'(bus.res_id), order[t]);
        end

        // ptr=1 with requests 1001: 3 then 0, ptr ends at 1
        bus.req = 4'b1001;
        wait_gnt(idx, at);
        bus.req = 4'b0001;
        chk("lit_ptr_first", idx, 3);
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_ptr_second", idx, 0);
        repeat (4) @(negedge clk);
        bus.req = '1;
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_ptr_end", idx, 1);
        repeat (4) @(negedge clk);

        // Reset while waiting for an Ack that never comes
        stuck = 1'b1;
        bus.req = 4'b0100;
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_wa_id", idx, 2);
        repeat (3) @(negedge clk);
        chk("lit_wa_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("lit_ra_gnt",   32'(bus.gnt), 0);
        chk("lit_ra_rdy",   32'(bus.flt_rdy), 0);
        chk("lit_ra_din",   32'(bus.flt_din), 0);
        chk("lit_ra_rv",    32'(bus.res_valid), 0);
        chk("lit_ra_rdata", 32'(bus.res_data), 0);
        chk("lit_ra_resid", 32'(bus.res_id), 0);
        chk("lit_ra_busy",  32'(bus.busy), 0);
        reset = 1'b0;
        stuck = 1'b0;
        bus.req = 4'b1100;
        wait_gnt(idx, at);
        bus.req = 4'b1000;
        chk("lit_ra_next", idx, 2);
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_ra_then", idx, 3);
        repeat (4) @(negedge clk);

`ifdef FLT_SCHED_TIMEOUT_EN
        stuck = 1'b1;
        bus.req = 4'b0001;
        wait_gnt(idx, at);
        bus.req = 4'b0010;
        seen = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.to_err) begin
                seen = cyc;
                break;
            end
        end
        stuck = 1'b0;
        chk("lit_to_delay", seen - at, 16);
        wait_gnt(idx, at);
        bus.req = '0;
        chk("lit_to_next", idx, 1);
        chk("lit_to_gap", at - seen, 2);
        repeat (4) @(negedge clk);
`else
        seen = 0;
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_rr_sched.md
Name: filter_rr_sched

Overview:
- Round-robin scheduler sharing one Filter_simple datapath between N_REQ sample requesters (demodulator channels).
- Arbitrates requests and drives the filter's Rdy/DataIn.
- Waits for the filter's Ack, then returns the filtered word tagged with the requester ID.
- Sits between the per-channel sample sources and the filter, and between the filter and the downstream demodulator logic.

Parameters:
- N_REQ, 4, number of requesters (power of 2, 2..8).
- DW, 16, sample/result width.
- ID_W, 2, requester ID width (log2 N_REQ).
- TO_CYC, 15, max cycles waiting for Ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until granted.
- req_data  in  N_REQ*DW  packed samples; requester i occupies bits [i*DW +: DW]; stable while req[i]=1.
- gnt  out  N_REQ  one-hot, one-cycle pulse: sample of that requester captured.
- flt_rdy  out  1  to filter Rdy.
- flt_din  out  DW  to filter DataIn.
- flt_ack  in  1  from filter Ack.
- flt_dout  in  DW  from filter DataOut.
- res_valid  out  1  one-cycle pulse: res_data/res_id valid.
- res_data  out  DW  captured filter result.
- res_id  out  ID_W  requester owning res_data.
- busy  out  1  high in any state other than IDLE.
- to_err  out  1  one-cycle timeout pulse (always 0 without the optional feature).

Behaviour:
- Reset (sync, active-high): state=IDLE; ptr=0; gnt=0, flt_rdy=0, flt_din=0, res_valid=0, res_data=0, res_id=0, busy=0, to_err=0, timeout counter=0. Reset mid-transaction aborts immediately; no res_valid is produced for the aborted item.
- States: IDLE -> ISSUE -> WAIT_ACK -> COOL -> IDLE.
- IDLE:
  - If req != 0: winner = first set bit scanning from ptr upward, modulo N_REQ.
  - Registered: gnt<=onehot(winner), flt_din<=req_data[winner], flt_rdy<=1, res_id<=winner, ptr<=(winner+1) mod N_REQ, state<=ISSUE.
  - If req == 0: stay in IDLE; gnt=0.
- ISSUE:
  - gnt<=0, flt_rdy<=0, state<=WAIT_ACK.
  - flt_rdy is high for exactly one cycle, so the filter samples once.
- WAIT_ACK:
  - On flt_ack=1: res_data<=flt_dout, res_valid<=1, state<=COOL.
  - Otherwise remain in WAIT_ACK.
- COOL: res_valid<=0, state<=IDLE. This cycle covers the filter's Ready->Idle return; a new Rdy is never raised while the filter is in Ready.
- Timing:
  - gnt is high in the cycle after the IDLE decision edge.
  - res_valid is high 2 cycles after gnt (nominal filter).
  - Throughput: one sample per 4 cycles under continuous request.
- Fairness: a continuously requesting agent waits at most N_REQ-1 transactions.
- Simultaneous requests: resolved by ptr only; there is no fixed priority.
- req dropped before grant: it is simply not selected; no error.
- flt_ack outside WAIT_ACK: ignored.
- flt_din holds its last value after the transaction.
- Arithmetic: pointer increment wraps modulo N_REQ; no result arithmetic is done here. DC offset removal stays inside the filter.

Optional Feature:
- Macro: FLT_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_ACK has a counter, cleared on entry.
  - If flt_ack is still 0 after TO_CYC cycles in WAIT_ACK: to_err<=1 for one cycle, no res_valid, state<=COOL.
  - ptr has already advanced, so the next requester is served.
- Undefined: no counter; WAIT_ACK waits indefinitely; to_err tied to 0.

Decomposition:
- Package filter_sched_pkg: state enum (IDLE, ISSUE, WAIT_ACK, COOL), default widths DW/ID_W, default TO_CYC.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, ptr.
  - Outputs: winner index, any-valid flag.
  - Reusable by other shared-resource schedulers.

Test Plan:
- Reset then single request: req=4'b0010, req_data[1]=16'h1234 -> gnt=4'b0010 one cycle; flt_rdy one cycle with flt_din=16'h1234; res_valid 2 cycles after gnt with res_id=1 and res_data equal to the filter DataOut at Ack.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; gnt pulses 4 cycles apart; each res_id matches the preceding grant.
- Requests 4'b1001 with ptr=1 -> requester 3 granted first, then 0; ptr ends at 1.
- Ack stuck low, with FLT_SCHED_TIMEOUT_EN and TO_CYC=15 -> to_err pulses 15 cycles after entering WAIT_ACK; no res_valid; next request granted.
- Reset asserted in WAIT_ACK -> next cycle: all outputs zero, busy=0, no res_valid; a subsequent request to requester 2 is granted from ptr=0.
- Spurious flt_ack pulse while in IDLE -> no res_valid; state unchanged.
